// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction decoder and the IMEM loader:
// opcodes, CTRL subcodes, field positions, legality check and word packing.
package isa_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_ADD   = 6'd0;
  localparam logic [5:0] OPC_SUB   = 6'd1;
  localparam logic [5:0] OPC_AND   = 6'd2;
  localparam logic [5:0] OPC_OR    = 6'd3;
  localparam logic [5:0] OPC_XOR   = 6'd4;
  localparam logic [5:0] OPC_NOT   = 6'd5;
  localparam logic [5:0] OPC_SHL   = 6'd6;
  localparam logic [5:0] OPC_SHR   = 6'd7;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LT    = 6'd9;
  localparam logic [5:0] OPC_GT    = 6'd10;
  localparam logic [5:0] OPC_LOAD  = 6'd11;
  localparam logic [5:0] OPC_STORE = 6'd12;
  localparam logic [5:0] OPC_CTRL  = 6'd13;

  localparam logic [4:0] RD_JMP = 5'd0;
  localparam logic [4:0] RD_BEQ = 5'd1;
  localparam logic [4:0] RD_BLT = 5'd2;
  localparam logic [4:0] RD_BGT = 5'd3;

  localparam int OPC_LSB = 26;
  localparam int RA_LSB  = 21;
  localparam int RB_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMD_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE,
    ST_ERR
  } load_state_t;

  // CTRL reuses the rd field as a branch subcode, so rd matters only there.
  function automatic logic is_legal(input logic [5:0] opc, input logic [4:0] rd);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_NOT, OPC_SHL, OPC_SHR,
      OPC_ADDI, OPC_LT, OPC_GT, OPC_LOAD, OPC_STORE: ok = 1'b1;
      OPC_CTRL: begin
        case (rd)
          RD_JMP, RD_BEQ, RD_BLT, RD_BGT: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [INSTR_W-1:0] encode(input logic [5:0] opc,
                                                input logic [4:0] ra,
                                                input logic [4:0] rb,
                                                input logic [4:0] rd,
                                                input logic [10:0] imd);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OPC_LSB +: 6]  = opc;
    w[RA_LSB +: 5]   = ra;
    w[RB_LSB +: 5]   = rb;
    w[RD_LSB +: 5]   = rd;
    w[IMD_LSB +: 11] = imd;
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Field-tuple input stream plus IMEM write port of the loader.
// slave is the loader side; master is the host/memory environment side.
interface imem_loader_if #(
  parameter int AW   = 10,
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_opc;
  logic [4:0]      in_ra;
  logic [4:0]      in_rb;
  logic [4:0]      in_rd;
  logic [10:0]     in_imd;
  logic            imem_we;
  logic            imem_ready;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;

  modport slave (
    input  in_valid, in_opc, in_ra, in_rb, in_rd, in_imd, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_opc, in_ra, in_rb, in_rd, in_imd, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction encoder and program writer: packs field tuples into words,
// rejects illegal opcodes, and writes words to consecutive IMEM addresses.
module imem_loader
  import isa_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   err_index
);

  load_state_t   state;
  load_state_t   state_nxt;
  logic [AW-1:0] base_q;
  logic [AW:0]   count_q;
  logic [AW:0]   acc_cnt;
  logic [AW:0]   wr_cnt;
  logic          done_nxt;
  logic          start_ok;
  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;
  logic          last_write;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_flush;

  assign start_ok   = start && (state != ST_FILL);
  assign legal      = is_legal(bus.in_opc, bus.in_rd);
  assign accept     = bus.in_valid && bus.in_ready;
  assign push       = accept && legal;
  assign pop        = bus.imem_we && bus.imem_ready;
  assign last_write = ((wr_cnt + 1'b1) == count_q);
  assign fifo_flush = start_ok || (accept && !legal);

  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.in_ready  = (state == ST_FILL) && !fifo_full && (acc_cnt < count_q);
  assign bus.imem_we   = (state == ST_FILL) && !fifo_empty;
  assign bus.imem_addr = base_q + wr_cnt[AW-1:0];
  assign busy          = (state == ST_FILL);

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (push),
    .din   (encode(bus.in_opc, bus.in_ra, bus.in_rb, bus.in_rd, bus.in_imd)),
    .pop   (pop),
    .dout  (bus.imem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_FILL: begin
        if (accept && !legal) begin
          state_nxt = ST_ERR;
        end else if (pop && last_write) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        if (start) begin
          if (count == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_index <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (start_ok) begin
        base_q    <= base_addr;
        count_q   <= count;
        acc_cnt   <= '0;
        wr_cnt    <= '0;
        err       <= 1'b0;
        err_index <= '0;
      end else begin
        if (push) acc_cnt <= acc_cnt + 1'b1;
        if (accept && !legal) begin
          err       <= 1'b1;
          err_index <= acc_cnt;
        end
        if (pop) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: encoding, legality, address
// wrap (AW=4 instance), back-pressure, zero-count loads and mid-load reset.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] err_index;

  logic        start_b;
  logic [3:0]  base_b;
  logic [4:0]  count_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;
  logic [4:0]  err_index_b;

  int n_checks;
  int n_fail;

  logic [9:0]  log_addr [64];
  logic [31:0] log_data [64];
  int          wr_n;
  int          done_n;
  logic [3:0]  b_addr [8];
  logic [31:0] b_data [8];
  int          b_n;

  imem_loader_if #(.AW(10), .XLEN(32)) bus ();
  imem_loader_if #(.AW(4),  .XLEN(32)) bus_b ();

  imem_loader #(.XLEN(32), .AW(10), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_index (err_index)
  );

  imem_loader #(.XLEN(32), .AW(4), .DEPTH(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .base_addr (base_b),
    .count     (count_b),
    .bus       (bus_b),
    .busy      (busy_b),
    .done      (done_b),
    .err       (err_b),
    .err_index (err_index_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n   <= 0;
      done_n <= 0;
      b_n    <= 0;
    end else begin
      if (bus.imem_we && bus.imem_ready && wr_n < 64) begin
        log_addr[wr_n] <= bus.imem_addr;
        log_data[wr_n] <= bus.imem_wdata;
        wr_n           <= wr_n + 1;
      end
      if (done) done_n <= done_n + 1;
      if (bus_b.imem_we && bus_b.imem_ready && b_n < 8) begin
        b_addr[b_n] <= bus_b.imem_addr;
        b_data[b_n] <= bus_b.imem_wdata;
        b_n         <= b_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] base, input logic [10:0] cnt);
    base_addr = base;
    count     = cnt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic sendTuple(input logic [5:0] opc, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rd,
                           input logic [10:0] imd);
    int k;
    bus.in_opc   = opc;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_rd    = rd;
    bus.in_imd   = imd;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    checkOutput({tag, "_imem_we"}, {31'd0, bus.imem_we}, 32'd0);
    checkOutput({tag, "_imem_addr"}, {22'd0, bus.imem_addr}, 32'd0);
    checkOutput({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_err_index"}, {21'd0, err_index}, 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    bus.in_valid = 1'b0;
    bus.in_opc = '0;
    bus.in_ra = '0;
    bus.in_rb = '0;
    bus.in_rd = '0;
    bus.in_imd = '0;
    bus.imem_ready = 1'b1;
    start_b = 1'b0;
    base_b = '0;
    count_b = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_opc = '0;
    bus_b.in_ra = '0;
    bus_b.in_rb = '0;
    bus_b.in_rd = '0;
    bus_b.in_imd = '0;
    bus_b.imem_ready = 1'b1;

    #12;
    checkAllZero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single ADDI load");
    w0 = wr_n;
    d0 = done_n;
    applyStimulus(10'h010, 11'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sendTuple(6'd8, 5'd1, 5'd0, 5'd5, 11'h7FF);
    checkOutput("t1_we", {31'd0, bus.imem_we}, 32'd1);
    checkOutput("t1_addr_early", {22'd0, bus.imem_addr}, 32'h010);
    checkOutput("t1_wdata_early", bus.imem_wdata, 32'h20202FFF);
    waitDone(20);
    checkOutput("t1_err", {31'd0, err}, 32'd0);
    checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("t1_done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("t1_writes", wr_n - w0, 32'd1);
    checkOutput("t1_addr", {22'd0, log_addr[w0]}, 32'h010);
    checkOutput("t1_data", log_data[w0], 32'h20202FFF);
    checkOutput("t1_done_pulses", done_n - d0, 32'd1);

    $display("[TB] CTRL then ADD");
    w0 = wr_n;
    applyStimulus(10'h020, 11'd2);
    sendTuple(6'd13, 5'd2, 5'd3, 5'd1, 11'd0);
    sendTuple(6'd0, 5'd0, 5'd0, 5'd0, 11'd0);
    waitDone(20);
    tick();
    checkOutput("t2_writes", wr_n - w0, 32'd2);
    checkOutput("t2_addr0", {22'd0, log_addr[w0]}, 32'h020);
    checkOutput("t2_data0", log_data[w0], 32'h34430800);
    checkOutput("t2_addr1", {22'd0, log_addr[w0+1]}, 32'h021);
    checkOutput("t2_data1", log_data[w0+1], 32'h00000000);

    $display("[TB] illegal opcode as second tuple");
    w0 = wr_n;
    d0 = done_n;
    applyStimulus(10'h040, 11'd3);
    sendTuple(6'd0, 5'd1, 5'd2, 5'd3, 11'd4);
    sendTuple(6'd14, 5'd0, 5'd0, 5'd0, 11'd0);
    checkOutput("t3_err", {31'd0, err}, 32'd1);
    checkOutput("t3_err_index", {21'd0, err_index}, 32'd1);
    checkOutput("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("t3_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    checkOutput("t3_we_idle", {31'd0, bus.imem_we}, 32'd0);
    checkOutput("t3_err_held", {31'd0, err}, 32'd1);
    checkOutput("t3_writes", wr_n - w0, 32'd1);
    checkOutput("t3_addr0", {22'd0, log_addr[w0]}, 32'h040);
    checkOutput("t3_data0", log_data[w0], 32'h00221804);
    checkOutput("t3_no_done", done_n - d0, 32'd0);

    $display("[TB] CTRL with bad subcode first");
    w0 = wr_n;
    applyStimulus(10'h050, 11'd2);
    checkOutput("t4_err_cleared", {31'd0, err}, 32'd0);
    sendTuple(6'd13, 5'd1, 5'd1, 5'd4, 11'd9);
    repeat (3) tick();
    checkOutput("t4_err", {31'd0, err}, 32'd1);
    checkOutput("t4_err_index", {21'd0, err_index}, 32'd0);
    checkOutput("t4_writes", wr_n - w0, 32'd0);

    $display("[TB] back-pressure with in_valid held");
    w0 = wr_n;
    bus.imem_ready = 1'b0;
    applyStimulus(10'h100, 11'd3);
    bus.in_opc = 6'd1; bus.in_ra = 5'd3; bus.in_rb = 5'd4; bus.in_rd = 5'd5; bus.in_imd = 11'h010;
    bus.in_valid = 1'b1;
    tick();
    bus.in_opc = 6'd9; bus.in_ra = 5'd31; bus.in_rb = 5'd31; bus.in_rd = 5'd31; bus.in_imd = 11'h000;
    tick();
    bus.in_opc = 6'd12; bus.in_ra = 5'd0; bus.in_rb = 5'd0; bus.in_rd = 5'd0; bus.in_imd = 11'h555;
    checkOutput("t5_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_stall_we", {31'd0, bus.imem_we}, 32'd1);
      checkOutput("t5_stall_addr", {22'd0, bus.imem_addr}, 32'h100);
      checkOutput("t5_stall_wdata", bus.imem_wdata, 32'h04642810);
      tick();
    end
    checkOutput("t5_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.imem_ready = 1'b1;
    waitDone(30);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("t5_writes", wr_n - w0, 32'd3);
    checkOutput("t5_addr0", {22'd0, log_addr[w0]}, 32'h100);
    checkOutput("t5_data0", log_data[w0], 32'h04642810);
    checkOutput("t5_addr1", {22'd0, log_addr[w0+1]}, 32'h101);
    checkOutput("t5_data1", log_data[w0+1], 32'h27FFF800);
    checkOutput("t5_addr2", {22'd0, log_addr[w0+2]}, 32'h102);
    checkOutput("t5_data2", log_data[w0+2], 32'h30000555);

    $display("[TB] zero-count load");
    w0 = wr_n;
    applyStimulus(10'h123, 11'd0);
    checkOutput("t6_done", {31'd0, done}, 32'd1);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("t6_done_drop", {31'd0, done}, 32'd0);
    checkOutput("t6_writes", wr_n - w0, 32'd0);

    $display("[TB] address wrap on AW=4 instance");
    base_b  = 4'd15;
    count_b = 5'd2;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checkOutput("t7_in_ready", {31'd0, bus_b.in_ready}, 32'd1);
    bus_b.in_opc = 6'd13; bus_b.in_ra = 5'd0; bus_b.in_rb = 5'd0; bus_b.in_rd = 5'd3; bus_b.in_imd = 11'd0;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_opc = 6'd7; bus_b.in_ra = 5'd1; bus_b.in_rb = 5'd1; bus_b.in_rd = 5'd1; bus_b.in_imd = 11'd1;
    tick();
    bus_b.in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("t7_writes", b_n, 32'd2);
    checkOutput("t7_addr0", {28'd0, b_addr[0]}, 32'd15);
    checkOutput("t7_data0", b_data[0], 32'h34001800);
    checkOutput("t7_addr1", {28'd0, b_addr[1]}, 32'd0);
    checkOutput("t7_data1", b_data[1], 32'h1C210801);
    checkOutput("t7_err", {31'd0, err_b}, 32'd0);

    $display("[TB] reset mid-load");
    applyStimulus(10'h200, 11'd3);
    sendTuple(6'd2, 5'd7, 5'd7, 5'd7, 11'h0AA);
    checkOutput("t8_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("t8_reset");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t8_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("t8_idle_ready", {31'd0, bus.in_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
